// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers, programmable multiply latency,
// a fixed-latency radix-2 restoring divider and MADD/MSUB accumulate modes.
module mdu_iter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [3:0]       MDOp,
  input  logic [1:0]       MTOp,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  // Counter must hold both WIDTH-1 and MUL_LAT-1 (at most 14).
  localparam int unsigned CntW = (WIDTH > 16) ? $clog2(WIDTH) : 4;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;

  logic               op_valid, op_div, div_signed, mul_signed, rem_ge;
  logic [WIDTH-1:0]   abs_a, abs_b, rem_sub;
  logic [WIDTH:0]     rem_sh;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, hilo;

  assign op_valid   = (MDOp >= 4'd1) && (MDOp <= 4'd8);
  assign op_div     = (MDOp == 4'd3) || (MDOp == 4'd4);
  assign div_signed = (MDOp == 4'd3);
  assign abs_a      = (div_signed && A1[WIDTH-1]) ? -A1 : A1;
  assign abs_b      = (div_signed && A2[WIDTH-1]) ? -A2 : A2;

  assign mul_signed = (op_q == 4'd1) || (op_q == 4'd5) || (op_q == 4'd7);
  assign ext_a = mul_signed ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
  assign ext_b = mul_signed ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
  assign prod  = ext_a * ext_b;
  assign hilo  = {hi_q, lo_q};

  // opa_q doubles as the dividend/quotient shift register during division.
  assign rem_sh  = {rem_q, opa_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, opb_q};
  assign rem_sub = rem_sh[WIDTH-1:0] - opb_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && op_valid) begin
          op_d = MDOp;
          if (op_div) begin
            opa_d   = abs_a;
            opb_d   = abs_b;
            rem_d   = '0;
            qneg_d  = div_signed && (A1[WIDTH-1] ^ A2[WIDTH-1]);
            rneg_d  = div_signed && A1[WIDTH-1];
            cnt_d   = CntW'(WIDTH - 1);
            state_d = StDiv;
          end else begin
            opa_d   = A1;
            opb_d   = A2;
            cnt_d   = CntW'(MUL_LAT - 1);
            state_d = StMul;
          end
        end else if (!start) begin
          if (MTOp == 2'd1) hi_d = A1;
          if (MTOp == 2'd2) lo_d = A1;
        end
      end
      StMul: begin
        if (cnt_q == '0) begin
          case (op_q)
            4'd5, 4'd6: {hi_d, lo_d} = hilo + prod;
            4'd7, 4'd8: {hi_d, lo_d} = hilo - prod;
            default:    {hi_d, lo_d} = prod;
          endcase
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDiv: begin
        rem_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
        opa_d = {opa_q[WIDTH-2:0], rem_ge};
        if (cnt_q == '0) state_d = StFix;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StFix: begin
        // Divide by zero keeps HI/LO but still completes with done.
        if (opb_q != '0) begin
          lo_d = qneg_q ? -opa_q : opa_q;
          hi_d = rneg_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: a 32-bit/5-cycle and an 8-bit/2-cycle instance, each checked every
// cycle against an arithmetic model, plus directed literal checks and random traffic.
module tb_mdu_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s[2];
  logic        start_s[2];
  logic [3:0]  mdop_s[2];
  logic [1:0]  mtop_s[2];
  logic [31:0] a1_s[2];
  logic [31:0] a2_s[2];

  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  mdu_iter #(.WIDTH(32), .MUL_LAT(5)) u_dut32 (
    .Clk(clk), .Reset(rst_s[0]), .A1(a1_s[0]), .A2(a2_s[0]), .MDOp(mdop_s[0]),
    .MTOp(mtop_s[0]), .start(start_s[0]), .busy(busy32), .done(done32), .Hi(hi32), .Lo(lo32)
  );

  mdu_iter #(.WIDTH(8), .MUL_LAT(2)) u_dut8 (
    .Clk(clk), .Reset(rst_s[1]), .A1(a1_s[1][7:0]), .A2(a2_s[1][7:0]), .MDOp(mdop_s[1]),
    .MTOp(mtop_s[1]), .start(start_s[1]), .busy(busy8), .done(done8), .Hi(hi8), .Lo(lo8)
  );

  function automatic int wid(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 5 : 2;
  endfunction

  function automatic logic [31:0] wmask(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic bz(input int i);
    return (i == 0) ? busy32 : busy8;
  endfunction

  function automatic logic dn(input int i);
    return (i == 0) ? done32 : done8;
  endfunction

  function automatic logic [31:0] hi_of(input int i);
    return (i == 0) ? hi32 : {24'd0, hi8};
  endfunction

  function automatic logic [31:0] lo_of(input int i);
    return (i == 0) ? lo32 : {24'd0, lo8};
  endfunction

  function automatic longint sx(input logic [31:0] x, input int w);
    if (x[w-1]) return longint'(x) - (longint'(1) << w);
    return longint'(x);
  endfunction

  // New {HI,LO} (packed as hi<<w | lo) produced by op on a, b given the current {HI,LO}.
  function automatic logic [63:0] result(input int w, input logic [3:0] op,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [63:0] hilo);
    logic [63:0] m2, wm, p;
    longint      sa, sb, q, r;
    m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    wm = 64'(wmask(w));
    sa = sx(a, w);
    sb = sx(b, w);
    q  = 0;
    r  = 0;
    if (op == 4'd1 || op == 4'd5 || op == 4'd7) p = 64'(sa * sb);
    else                                        p = 64'(a) * 64'(b);
    case (op)
      4'd1, 4'd2: return p & m2;
      4'd5, 4'd6: return (hilo + p) & m2;
      4'd7, 4'd8: return (hilo - p) & m2;
      4'd3: begin
        if (b == 32'd0) return hilo;
        q = sa / sb;
        r = sa % sb;
      end
      4'd4: begin
        if (b == 32'd0) return hilo;
        q = longint'(a / b);
        r = longint'(a % b);
      end
      default: return hilo;
    endcase
    return ((64'(r) & wm) << w) | (64'(q) & wm);
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [inst%0d] at %0t: got 0x%0h, expected 0x%0h", nm, i, $time, act, exp);
    end
  endtask

  // Model: an accepted op completes a fixed number of cycles later; HI/LO change only then,
  // or through MTHI/MTLO when idle and start is low.
  logic [31:0] m_hi[2]   = '{32'd0, 32'd0};
  logic [31:0] m_lo[2]   = '{32'd0, 32'd0};
  logic [31:0] m_a[2]    = '{32'd0, 32'd0};
  logic [31:0] m_b[2]    = '{32'd0, 32'd0};
  logic [3:0]  m_op[2]   = '{4'd0, 4'd0};
  int          m_rem[2]  = '{0, 0};
  logic        m_done[2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_s[i]) begin
        m_hi[i]   <= 32'd0;
        m_lo[i]   <= 32'd0;
        m_rem[i]  <= 0;
        m_done[i] <= 1'b0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_rem[i] > 0) begin
          m_rem[i] <= m_rem[i] - 1;
          if (m_rem[i] == 1) begin
            m_hi[i] <= 32'(result(wid(i), m_op[i], m_a[i], m_b[i],
                                  (64'(m_hi[i]) << wid(i)) | 64'(m_lo[i])) >> wid(i));
            m_lo[i] <= 32'(result(wid(i), m_op[i], m_a[i], m_b[i],
                                  (64'(m_hi[i]) << wid(i)) | 64'(m_lo[i]))) & wmask(wid(i));
            m_done[i] <= 1'b1;
          end
        end else if (start_s[i] && mdop_s[i] >= 4'd1 && mdop_s[i] <= 4'd8) begin
          m_op[i]  <= mdop_s[i];
          m_a[i]   <= a1_s[i] & wmask(wid(i));
          m_b[i]   <= a2_s[i] & wmask(wid(i));
          m_rem[i] <= (mdop_s[i] == 4'd3 || mdop_s[i] == 4'd4) ? wid(i) + 1 : lat(i);
        end else if (!start_s[i]) begin
          if (mtop_s[i] == 2'd1) m_hi[i] <= a1_s[i] & wmask(wid(i));
          if (mtop_s[i] == 2'd2) m_lo[i] <= a1_s[i] & wmask(wid(i));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, 64'(bz(i)), 64'(m_rem[i] != 0));
        chk("done", i, 64'(dn(i)), 64'(m_done[i]));
        chk("hi", i, 64'(hi_of(i)), 64'(m_hi[i]));
        chk("lo", i, 64'(lo_of(i)), 64'(m_lo[i]));
      end
    end
  end

  function automatic logic [31:0] pick(input int w);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'd1 << (w - 1);
      4:       v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v & wmask(w);
  endfunction

  task automatic wait_done(input int i, input int c0, output int cyc);
    cyc = c0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!dn(i) && cyc < 100);
    chk("done_seen", i, 64'(dn(i)), 64'd1);
  endtask

  task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] mt, output int cyc);
    start_s[i] = 1'b1;
    mdop_s[i]  = op;
    mtop_s[i]  = mt;
    a1_s[i]    = a;
    a2_s[i]    = b;
    @(posedge clk);
    #1;
    start_s[i] = 1'b0;
    mdop_s[i]  = 4'd0;
    mtop_s[i]  = 2'd0;
    wait_done(i, 0, cyc);
  endtask

  task automatic mt(input int i, input logic [1:0] op, input logic [31:0] v);
    mtop_s[i] = op;
    a1_s[i]   = v;
    @(posedge clk);
    #1;
    mtop_s[i] = 2'd0;
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 2; i++) begin
      rst_s[i]   = 1'b1;
      start_s[i] = 1'b0;
      mdop_s[i]  = 4'd0;
      mtop_s[i]  = 2'd0;
      a1_s[i]    = 32'd0;
      a2_s[i]    = 32'd0;
    end
    @(posedge clk);
    #1;
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    chk_en   = 1'b1;
    chk("rst_busy", 0, 64'(busy32), 64'd0);
    chk("rst_hi", 0, 64'(hi32), 64'd0);

    issue(0, 4'd1, 32'hFFFF_FFFE, 32'd3, 2'd0, cyc);
    chk("mult_lat", 0, 64'(cyc), 64'd5);
    chk("mult_hi", 0, 64'(hi32), 64'hFFFF_FFFF);
    chk("mult_lo", 0, 64'(lo32), 64'hFFFF_FFFA);
    issue(0, 4'd2, 32'hFFFF_FFFE, 32'd3, 2'd0, cyc);
    chk("multu_hi", 0, 64'(hi32), 64'h2);
    chk("multu_lo", 0, 64'(lo32), 64'hFFFF_FFFA);

    issue(0, 4'd3, 32'hFFFF_FFF9, 32'd2, 2'd0, cyc);
    chk("div_lat", 0, 64'(cyc), 64'd33);
    chk("div_lo", 0, 64'(lo32), 64'hFFFF_FFFD);
    chk("div_hi", 0, 64'(hi32), 64'hFFFF_FFFF);
    issue(0, 4'd4, 32'd100, 32'd7, 2'd0, cyc);
    chk("divu_lo", 0, 64'(lo32), 64'd14);
    chk("divu_hi", 0, 64'(hi32), 64'd2);

    mt(0, 2'd1, 32'd0);
    mt(0, 2'd2, 32'd10);
    issue(0, 4'd5, 32'd3, 32'd4, 2'd0, cyc);
    chk("madd_lo", 0, 64'(lo32), 64'd22);
    issue(0, 4'd8, 32'd1, 32'h20, 2'd0, cyc);
    chk("msubu_lo", 0, 64'(lo32), 64'hFFFF_FFF6);
    chk("msubu_hi", 0, 64'(hi32), 64'hFFFF_FFFF);

    mt(0, 2'd1, 32'd5);
    mt(0, 2'd2, 32'd6);
    issue(0, 4'd3, 32'd123, 32'd0, 2'd0, cyc);
    chk("div0_lat", 0, 64'(cyc), 64'd33);
    chk("div0_hi", 0, 64'(hi32), 64'd5);
    chk("div0_lo", 0, 64'(lo32), 64'd6);

    issue(0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0, cyc);
    chk("divmin_lo", 0, 64'(lo32), 64'h8000_0000);
    chk("divmin_hi", 0, 64'(hi32), 64'd0);

    mt(0, 2'd1, 32'h55);
    issue(0, 4'd4, 32'h77, 32'd0, 2'd1, cyc);
    chk("mt_drop_hi", 0, 64'(hi32), 64'h55);

    // A second start plus MTHI arrives while the multiply is in flight.
    start_s[0] = 1'b1; mdop_s[0] = 4'd1; a1_s[0] = 32'd7; a2_s[0] = 32'd6;
    @(posedge clk); #1;
    start_s[0] = 1'b0; mdop_s[0] = 4'd0;
    @(posedge clk); #1;
    start_s[0] = 1'b1; mdop_s[0] = 4'd4; mtop_s[0] = 2'd1; a1_s[0] = 32'h1234; a2_s[0] = 32'd1;
    @(posedge clk); #1;
    start_s[0] = 1'b0; mdop_s[0] = 4'd0; mtop_s[0] = 2'd0;
    wait_done(0, 2, cyc);
    chk("busy_start_lat", 0, 64'(cyc), 64'd5);
    chk("busy_start_lo", 0, 64'(lo32), 64'd42);
    chk("busy_start_hi", 0, 64'(hi32), 64'd0);

    start_s[0] = 1'b1; mdop_s[0] = 4'd3; a1_s[0] = 32'd1000; a2_s[0] = 32'd3;
    @(posedge clk); #1;
    start_s[0] = 1'b0; mdop_s[0] = 4'd0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_s[0] = 1'b1;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    chk("abort_busy", 0, 64'(busy32), 64'd0);
    chk("abort_done", 0, 64'(done32), 64'd0);
    chk("abort_lo", 0, 64'(lo32), 64'd0);
    repeat (40) begin
      @(posedge clk); #1;
    end

    issue(1, 4'd1, 32'h80, 32'h80, 2'd0, cyc);
    chk("w8_mult_lat", 1, 64'(cyc), 64'd2);
    chk("w8_mult_hi", 1, 64'(hi8), 64'h40);
    chk("w8_mult_lo", 1, 64'(lo8), 64'h00);
    issue(1, 4'd1, 32'd3, 32'd5, 2'd0, cyc);
    chk("w8_b2b_lat", 1, 64'(cyc), 64'd2);
    chk("w8_b2b_lo", 1, 64'(lo8), 64'd15);
    issue(1, 4'd3, 32'hF9, 32'd2, 2'd0, cyc);
    chk("w8_div_lat", 1, 64'(cyc), 64'd9);
    chk("w8_div_lo", 1, 64'(lo8), 64'hFD);
    chk("w8_div_hi", 1, 64'(hi8), 64'hFF);
    issue(1, 4'd3, 32'h80, 32'hFF, 2'd0, cyc);
    chk("w8_divmin_lo", 1, 64'(lo8), 64'h80);

    repeat (3000) begin
      for (int i = 0; i < 2; i++) begin
        rst_s[i]   = ($urandom_range(0, 299) == 0);
        start_s[i] = ($urandom_range(0, 2) == 0);
        mdop_s[i]  = 4'($urandom_range(0, 15));
        mtop_s[i]  = 2'($urandom_range(0, 3));
        a1_s[i]    = pick(wid(i));
        a2_s[i]    = pick(wid(i));
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      rst_s[i]   = 1'b0;
      start_s[i] = 1'b0;
      mdop_s[i]  = 4'd0;
      mtop_s[i]  = 2'd0;
    end
    repeat (50) begin
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised multiply/divide unit for the MIPS EX stage, successor to the fixed-latency 32-bit HI/LO unit. It keeps the same start/busy/HI/LO contract towards the hazard unit. It adds several capabilities:
- data width as a parameter;
- a programmable multiply latency;
- a true iterative radix-2 divider with fixed, data-independent latency;
- MADD/MADDU/MSUB/MSUBU accumulate modes;
- a one-cycle `done` pulse.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width (≥ 4)
- MUL_LAT, 5, cycles busy is held for multiply-class ops (1..15)

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- A1  input  WIDTH  rs operand; also the MTHI/MTLO source
- A2  input  WIDTH  rt operand
- MDOp  input  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9–15 none
- MTOp  input  2  0 none, 1 MTHI, 2 MTLO, 3 none
- start  input  1  launch the MDOp operation this cycle
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse in the cycle HI/LO first show a new result
- Hi  output  WIDTH  HI register
- Lo  output  WIDTH  LO register

## Operation
- State machine states: IDLE, MUL, DIV, FIX.
- Reset: all outputs are 0; state is IDLE; the iteration counter and internal product/remainder/quotient registers are 0.

IDLE
- `start` with a valid MDOp:
  - Latch operands and op.
  - Go to MUL (ops 1, 2, 5–8) or DIV (ops 3, 4).
- `start` with MDOp "none": ignored; no busy.
- No `start` and MTOp = 1: Hi ← A1. MTOp = 2: Lo ← A1.
- `start` and MTOp in the same cycle: `start` wins and the MT is dropped.

MUL
- Product is the full 2·WIDTH-bit value: signed for ops 1, 5, 7; unsigned for ops 2, 6, 8.
- Hold for MUL_LAT cycles, then write:
  - MULT/MULTU: {Hi,Lo} ← product.
  - MADD(U): {Hi,Lo} ← {Hi,Lo} + product.
  - MSUB(U): {Hi,Lo} ← {Hi,Lo} − product.
- Accumulate arithmetic is modulo 2^(2·WIDTH), with no overflow flag.
- The accumulate uses the {Hi,Lo} value at write time.

DIV
- Restoring shift-subtract on |A1| and |A2| (raw values for DIVU).
- One quotient bit per cycle for WIDTH cycles, then go to FIX.

FIX
- Apply signs: quotient truncates toward zero; remainder takes the dividend's sign.
- Write Lo ← quotient, Hi ← remainder.
- Divisor 0: Hi/Lo are left unchanged, but the full latency and the `done` pulse still occur.
- DIV of the most negative value by −1: Lo ← most negative value, Hi ← 0.

While busy
- `start` and MTOp are ignored. The hazard unit stalls, so this is never expected; ignoring them is still required.
- Hi/Lo hold their old values until the write cycle; MFHI/MFLO during busy are stalled externally.

Reset
- Reset mid-operation aborts the operation: state is IDLE, busy = 0, done = 0, Hi = Lo = 0 at the next edge.
- Reset has priority over `start` and MTOp.

## Timing
- `start` is sampled at edge E0; busy is high from E0 to the writeback edge.
- Multiply: the writeback edge is E0+MUL_LAT, so busy is high for MUL_LAT cycles.
- Divide: the writeback edge is E0+WIDTH+1 (WIDTH iterations plus FIX), so busy is high for WIDTH+1 cycles (33 at WIDTH=32).
- At the writeback edge: Hi/Lo update, busy falls, and `done` rises for exactly one cycle.
- A new `start` is accepted in the cycle `done` is high, giving back-to-back issue with no gap.
- MTHI/MTLO take effect at the sampling edge; they have no busy and no `done`.
- Latency is independent of operand values.

## Test plan
- Reset, then MULT A1=0xFFFFFFFE (−2), A2=3 → busy for 5 cycles, then Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, done pulses once. Repeat as MULTU → Hi=0x00000002, Lo=0xFFFFFFFA.
- DIV A1=0xFFFFFFF9 (−7), A2=2 → busy for 33 cycles, then Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 100/7 → Lo=14, Hi=2.
- MTHI 0, MTLO 10, then MADD 3×4 → Lo=22. MSUBU 0x1×0x20 → Lo=0xFFFFFFF6, Hi=0xFFFFFFFF (borrow wraps).
- Division edges:
  - DIV with A2=0 and Hi/Lo preloaded to 0x5/0x6 → both unchanged after 33 cycles, done pulses.
  - DIV 0x80000000/−1 → Lo=0x80000000, Hi=0.
- Collisions:
  - MTOp=1 together with `start` → MT dropped.
  - `start` during busy → ignored and the original result is written.
  - Reset at cycle 10 of a DIV → busy=0, Hi=Lo=0, no done.
- WIDTH=8, MUL_LAT=2: MULT 0x80×0x80 → Hi=0x40, Lo=0x00 after 2 cycles. DIV busy for 9 cycles. Back-to-back MULT issued on the done cycle is accepted.
